// File: rtl/dmem_if.sv
// Data-memory request/response bundle between the pipeline's memory stage
// (master) and the memory responder (slave).
interface dmem_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: 256 x 16-bit words, power-up clear,
// programmable wait states and a one-cycle response strobe.
module dmem_responder #(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 16
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** (ADDR_W - 1);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-2:0] clear_ptr;
  logic [3:0]        wcnt_p0;
  logic              write_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept, commit, cm_write, cm_misaligned;
  logic [ADDR_W-1:0] cm_addr;
  logic [DATA_W-1:0] cm_wdata;
  logic [ADDR_W-2:0] cm_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT: if (&clear_ptr) state_nxt = IDLE;
      IDLE: if (bus.req_valid) state_nxt = (WS == 4'd0) ? RESP : WAIT;
      WAIT: if (wcnt_p0 == 4'd1) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // With zero wait states the access commits on the accept edge itself,
  // so the commit operands come straight off the bus in IDLE.
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.busy      = (state != IDLE);
    accept        = (state == IDLE) && bus.req_valid;
    commit        = (state_nxt == RESP) && (state != RESP);
    if (state == IDLE) begin
      cm_write = bus.req_write;
      cm_addr  = bus.req_addr;
      cm_wdata = bus.req_wdata;
    end else begin
      cm_write = write_p0;
      cm_addr  = addr_p0;
      cm_wdata = wdata_p0;
    end
    cm_misaligned = cm_addr[0];
    cm_idx        = cm_addr[ADDR_W-1:1];
  end

  // Stage p0: control and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      clear_ptr      <= '0;
      wcnt_p0        <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      if (state == INIT) clear_ptr <= clear_ptr + 1'b1;
      if (accept)              wcnt_p0 <= WS;
      else if (state == WAIT)  wcnt_p0 <= wcnt_p0 - 4'd1;
      bus.resp_valid <= commit;
      if (commit) begin
        bus.resp_err   <= cm_misaligned;
        bus.resp_rdata <= (cm_write || cm_misaligned) ? '0 : mem[cm_idx];
      end
    end
  end

  // Stage p0: request payload, held for the wait-state commit
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p0 <= bus.req_write;
      addr_p0  <= bus.req_addr;
      wdata_p0 <= bus.req_wdata;
    end
  end

  // A commit edge that coincides with reset must not touch memory.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)
        mem[clear_ptr] <= '0;
      else if (commit && cm_write && !cm_misaligned)
        mem[cm_idx] <= cm_wdata;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a word-array memory model.
module tb_dmem_responder;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if #(.ADDR_W(9), .DATA_W(16)) bus ();
  dmem_responder #(.WAIT_STATES(W), .ADDR_W(9), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int unsigned acc;
  } exp_t;

  int          passed = 0;
  int          total = 0;
  int unsigned ecnt = 0;
  logic [15:0] model [256];
  exp_t        sbq [$];
  int unsigned acc_times [$];
  logic        prev_rv = 1'b0;
  int          busy_bad = 0;
  int          resp_cnt = 0;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: accepts push expectations from the model, responses pop and compare.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      for (int i = 0; i < 256; i++) model[i] = 16'h0000;
    end else begin
      if (bus.busy === bus.req_ready) busy_bad++;
      if (bus.resp_valid) begin
        resp_cnt++;
        check("resp_width", {31'd0, prev_rv}, 32'd0);
        check("resp_expected", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          check("resp_rdata", {16'd0, bus.resp_rdata}, {16'd0, e.rdata});
          check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
          // Accept sampled one negedge before its edge; response edge is W edges later.
          check("resp_latency", ecnt - e.acc, W + 1);
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        exp_t e;
        e.acc = ecnt;
        if (bus.req_addr[0]) begin
          e.rdata = 16'h0000; e.err = 1'b1;
        end else if (bus.req_write) begin
          model[bus.req_addr[8:1]] = bus.req_wdata;
          e.rdata = 16'h0000; e.err = 1'b0;
        end else begin
          e.rdata = model[bus.req_addr[8:1]]; e.err = 1'b0;
        end
        sbq.push_back(e);
        acc_times.push_back(ecnt);
      end
    end
    prev_rv = bus.resp_valid;
  end

  task automatic release_and_check_init();
    int n = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("init_cycles", 32'(n), 32'd256);
  endtask

  task automatic issue(input logic wr, input logic [8:0] a, input logic [15:0] d);
    int n = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = d;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", 32'(n), 32'd0);
  endtask

  logic [8:0] pool [5] = '{9'h010, 9'h020, 9'h1FE, 9'h000, 9'h011};

  initial begin
    int rc;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", {16'd0, bus.resp_rdata}, 32'd0);
    check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd1);
    release_and_check_init();

    issue(1'b0, 9'h1FE, 16'h0);
    issue(1'b1, 9'h010, 16'hBEEF);
    issue(1'b0, 9'h010, 16'h0);
    issue(1'b1, 9'h011, 16'h1234);
    issue(1'b0, 9'h010, 16'h0);
    issue(1'b1, 9'h1FE, 16'hA5A5);
    issue(1'b0, 9'h000, 16'h0);
    issue(1'b0, 9'h1FE, 16'h0);
    drain();

    // req_valid held for 12 cycles starting in IDLE
    acc_times.delete();
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 9'h010;
    repeat (12) @(posedge clk);
    #1 bus.req_valid = 1'b0;
    drain();
    check("tput_accepts", 32'(acc_times.size()), 32'd3);
    if (acc_times.size() == 3) begin
      check("tput_gap0", acc_times[1] - acc_times[0], 32'(W + 2));
      check("tput_gap1", acc_times[2] - acc_times[1], 32'(W + 2));
    end

    for (int i = 0; i < 80; i++) begin
      logic [8:0] a;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      a = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 4)] : 9'($urandom_range(0, 511));
      issue(1'($urandom_range(0, 1)), a, 16'($urandom));
    end
    drain();

    // Reset while the write sits in WAIT
    issue(1'b1, 9'h020, 16'h5555);
    rst = 1'b1;
    rc = resp_cnt;
    repeat (2) @(posedge clk);
    release_and_check_init();
    check("resp_during_rst", 32'(resp_cnt - rc), 32'd0);
    issue(1'b0, 9'h020, 16'h0);
    issue(1'b0, 9'h010, 16'h0);
    issue(1'b0, 9'h1FE, 16'h0);
    drain();
    repeat (2) @(negedge clk);

    check("busy_decode", 32'(busy_bad), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
